// File: rtl/cpu_pkg.sv
// Shared types and constants for the small ALU-controller CPU slice:
// opcode encoding, external ALU select codes, FSM states and carry policy.
package cpu_pkg;

    // Datapath geometry
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 4;
    localparam int REG_AW   = 2;

    // Instruction opcodes, taken from instr[7:5]
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_AND = 3'b001,
        OP_SUB = 3'b010,
        OP_INC = 3'b011,
        OP_ADC = 3'b100,
        OP_SBB = 3'b101,
        OP_MOV = 3'b110,
        OP_LDI = 3'b111
    } opcode_e;

    // External ALU select codes
    localparam logic [4:0] ALU_SEL_ADD    = 5'b00000;  // a + b
    localparam logic [4:0] ALU_SEL_AND    = 5'b00001;  // a & b
    localparam logic [4:0] ALU_SEL_SUB    = 5'b01100;  // a - b
    localparam logic [4:0] ALU_SEL_INC    = 5'b10100;  // a + 1
    localparam logic [4:0] ALU_SEL_ADC    = 5'b00100;  // a + b + 1
    localparam logic [4:0] ALU_SEL_SBB    = 5'b01000;  // a - b - 1
    localparam logic [4:0] ALU_SEL_PASS_B = 5'b00011;  // b
    localparam logic [4:0] ALU_SEL_IDLE   = 5'b00010;  // parked select outside EXEC

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,  // waiting for an opcode byte
        ST_IMM  = 2'b01,  // waiting for the LDI immediate byte
        ST_EXEC = 2'b10,  // ALU operands driven, result written at the end
        ST_WB   = 2'b11   // completion pulse
    } state_e;

    // How an instruction treats the carry flag
    typedef enum logic [1:0] {
        CF_FROM_ALU = 2'b00,
        CF_CLEAR    = 2'b01,
        CF_HOLD     = 2'b10
    } carry_upd_e;

    // ALU select for an opcode; ADC/SBB fold the current carry into the select.
    function automatic logic [4:0] alu_sel_of(input opcode_e op, input logic carry);
        logic [4:0] sel;
        sel = ALU_SEL_IDLE;
        unique case (op)
            OP_ADD:  sel = ALU_SEL_ADD;
            OP_AND:  sel = ALU_SEL_AND;
            OP_SUB:  sel = ALU_SEL_SUB;
            OP_INC:  sel = ALU_SEL_INC;
            OP_ADC:  sel = carry ? ALU_SEL_ADC : ALU_SEL_ADD;
            OP_SBB:  sel = carry ? ALU_SEL_SBB : ALU_SEL_SUB;
            OP_MOV:  sel = ALU_SEL_PASS_B;
            OP_LDI:  sel = ALU_SEL_PASS_B;
            default: sel = ALU_SEL_IDLE;
        endcase
        return sel;
    endfunction

    // Carry-flag policy for an opcode.
    function automatic carry_upd_e carry_upd_of(input opcode_e op);
        carry_upd_e upd;
        upd = CF_HOLD;
        unique case (op)
            OP_ADD, OP_SUB, OP_INC, OP_ADC, OP_SBB: upd = CF_FROM_ALU;
            OP_AND:                                 upd = CF_CLEAR;
            default:                                upd = CF_HOLD;
        endcase
        return upd;
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Four 8-bit registers: two combinational operand read ports, one debug
// read port and a single synchronous write port.
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic [REG_AW-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Register storage: cleared by reset, one write per cycle.
    // NOTE: this array is small flops, not a RAM macro, so it is reset like any
    // other state; reset software must see all-zero registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                // NOTE: non-blocking so every flop samples pre-edge values.
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Reads see the stored value, so rd==rs both get the pre-write value.
    assign rdata_a_o  = regs_q[raddr_a_i];
    assign rdata_b_o  = regs_q[raddr_b_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/cpu_alu_ctrl.sv
// Byte-serial instruction controller driving an external ALU. Opcode byte
// (plus an immediate byte for LDI) -> one EXEC cycle -> one WB done pulse.
module cpu_alu_ctrl
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_z,
    input  logic              alu_cout,
    output logic              done,
    output logic              flag_c,
    output logic              flag_z,
    input  logic [REG_AW-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    state_e            state_q, state_d;
    opcode_e           op_q, op_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [REG_AW-1:0] rs_q, rs_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              flag_c_q, flag_c_d;
    logic              flag_z_q, flag_z_d;

    logic              xfer;
    opcode_e           instr_op;
    logic              rf_we;
    logic [DATA_W-1:0] rf_rdata_a;
    logic [DATA_W-1:0] rf_rdata_b;

    assign instr_ready = (state_q == ST_IDLE) || (state_q == ST_IMM);
    assign xfer        = instr_valid && instr_ready;
    assign instr_op    = opcode_e'(instr[7:5]);
    assign done        = (state_q == ST_WB);
    assign flag_c      = flag_c_q;
    assign flag_z      = flag_z_q;

    cpu_regfile u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (rf_we),
        .waddr_i    (rd_q),
        .wdata_i    (alu_z),
        .raddr_a_i  (rd_q),
        .rdata_a_o  (rf_rdata_a),
        .raddr_b_i  (rs_q),
        .rdata_b_o  (rf_rdata_b),
        .dbg_addr_i (dbg_sel),
        .dbg_data_o (dbg_data)
    );

    // Next state and byte capture from the instruction handshake.
    always_comb begin
        // NOTE: every signal gets its hold value first, so no path leaves one
        // unassigned and no latch is inferred.
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rs_d    = rs_q;
        imm_d   = imm_q;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    op_d    = instr_op;
                    rd_d    = instr[4:3];
                    rs_d    = instr[2:1];
                    state_d = (instr_op == OP_LDI) ? ST_IMM : ST_EXEC;
                end
            end
            ST_IMM: begin
                if (xfer) begin
                    imm_d   = instr;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // EXEC datapath: drive the ALU, write back its result and update flags.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_sel  = ALU_SEL_IDLE;
        rf_we    = 1'b0;
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        if (state_q == ST_EXEC) begin
            alu_a    = rf_rdata_a;
            alu_b    = (op_q == OP_LDI) ? imm_q : rf_rdata_b;
            // ADC/SBB see the carry from before this instruction.
            alu_sel  = alu_sel_of(op_q, flag_c_q);
            rf_we    = 1'b1;
            flag_z_d = (alu_z == '0);
            if (carry_upd_of(op_q) == CF_FROM_ALU) begin
                flag_c_d = alu_cout;
            end else if (carry_upd_of(op_q) == CF_CLEAR) begin
                flag_c_d = 1'b0;
            end
        end
    end

    // Controller state; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            rd_q     <= '0;
            rs_q     <= '0;
            imm_q    <= '0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs_q     <= rs_d;
            imm_q    <= imm_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
        end
    end

endmodule
